// File: rtl/aes_enc_ctrl.sv
// Sequencer for a byte-serial AES encryption core: streams key/plaintext in MSB-first,
// collects 16 ciphertext bytes, hands the 128-bit result to a consumer; watchdog on core stalls.
//
// state   | meaning
// CRST    | core held in reset, then IDLE
// IDLE    | accepting a key/plaintext request
// LOAD    | streaming key/state byte pairs to the core
// WAIT    | waiting for the first ciphertext byte (watchdog running)
// COLLECT | gathering ciphertext bytes (watchdog runs in gaps)
// DONE    | result held until the consumer takes it
module aes_enc_ctrl #(
    parameter int TIMEOUT_CYCLES  = 256,
    parameter int CORE_RST_CYCLES = 2
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [127:0] in_key,
    input  logic [127:0] in_block,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [127:0] out_block,
    output logic         busy,
    output logic         timeout_err,
    output logic         core_rst,
    output logic         core_enable,
    output logic [7:0]   core_key_byte,
    output logic [7:0]   core_state_byte,
    input  logic         core_load,
    input  logic         core_ready,
    input  logic [7:0]   core_out_byte
);

    localparam logic [2:0] S_CRST    = 3'd0;
    localparam logic [2:0] S_IDLE    = 3'd1;
    localparam logic [2:0] S_LOAD    = 3'd2;
    localparam logic [2:0] S_WAIT    = 3'd3;
    localparam logic [2:0] S_COLLECT = 3'd4;
    localparam logic [2:0] S_DONE    = 3'd5;

    localparam int WDW = $clog2(TIMEOUT_CYCLES + 1);
    localparam int RCW = (CORE_RST_CYCLES > 1) ? $clog2(CORE_RST_CYCLES) : 1;
    localparam logic [WDW-1:0] WD_LAST = WDW'(TIMEOUT_CYCLES - 1);
    localparam logic [WDW-1:0] WD_TOP  = WDW'(TIMEOUT_CYCLES);
    localparam logic [RCW-1:0] RC_LOAD = RCW'(CORE_RST_CYCLES - 1);

    logic [2:0]     state;
    logic [4:0]     cnt;
    logic [WDW-1:0] wdog;
    logic [RCW-1:0] rcnt;
    logic [127:0]   key_sr;
    logic [127:0]   blk_sr;

    always_ff @(posedge clk) begin
        if (!rst) begin
            state       <= S_CRST;
            cnt         <= '0;
            wdog        <= '0;
            rcnt        <= RC_LOAD;
            key_sr      <= '0;
            blk_sr      <= '0;
            out_block   <= '0;
            timeout_err <= 1'b0;
        end else begin
            timeout_err <= 1'b0;
            case (state)
                S_CRST: begin
                    if (rcnt == '0) state <= S_IDLE;
                    else            rcnt  <= rcnt - RCW'(1);
                end
                S_IDLE: begin
                    if (in_valid) begin
                        key_sr <= in_key;
                        blk_sr <= in_block;
                        cnt    <= '0;
                        state  <= S_LOAD;
                    end
                end
                S_LOAD: begin
                    if (core_load) begin
                        key_sr <= {key_sr[119:0], 8'h00};
                        blk_sr <= {blk_sr[119:0], 8'h00};
                        cnt    <= cnt + 5'd1;
                        if (cnt == 5'd15) begin
                            state <= S_WAIT;
                            wdog  <= '0;
                        end
                    end
                end
                S_WAIT, S_COLLECT: begin
                    // core_ready wins over a coinciding timeout
                    if (core_ready) begin
                        out_block <= {out_block[119:0], core_out_byte};
                        wdog      <= '0;
                        if (state == S_WAIT) begin
                            cnt   <= 5'd1;
                            state <= S_COLLECT;
                        end else begin
                            cnt <= cnt + 5'd1;
                            if (cnt == 5'd15) state <= S_DONE;
                        end
                    end else begin
                        if (wdog < WD_TOP) wdog <= wdog + WDW'(1);
                        if (wdog >= WD_LAST) begin
                            timeout_err <= 1'b1;
                            out_block   <= '0;
                            rcnt        <= RC_LOAD;
                            state       <= S_CRST;
                        end
                    end
                end
                S_DONE: begin
                    if (out_ready) state <= S_IDLE;
                end
                default: begin
                    rcnt  <= RC_LOAD;
                    state <= S_CRST;
                end
            endcase
        end
    end

    assign in_ready        = (state == S_IDLE);
    assign busy            = (state != S_IDLE);
    assign out_valid       = (state == S_DONE);
    assign core_rst        = (state == S_CRST);
    assign core_enable     = (state == S_LOAD) || (state == S_WAIT);
    assign core_key_byte   = (state == S_LOAD) ? key_sr[127:120] : 8'h00;
    assign core_state_byte = (state == S_LOAD) ? blk_sr[127:120] : 8'h00;

endmodule
